// File: rtl/e203_dtcm_icb2sram_pkg.sv
// ---------------------------------------------------------------------------
// e203_dtcm_icb2sram_pkg
// Shared DTCM geometry (SRAM word address / data / mask widths, ICB address
// width) and the light-sleep idle threshold. e203_dtcm_ctrl instantiates the
// bridge with these values. It also holds a helper that sizes counters.
// ---------------------------------------------------------------------------
package e203_dtcm_icb2sram_pkg;

  localparam int E203_DTCM_RAM_AW     = 12;
  localparam int E203_DTCM_RAM_DW     = 32;
  localparam int E203_DTCM_RAM_MW     = 4;
  localparam int E203_DTCM_ADDR_WIDTH = 16;
  localparam int E203_DTCM_LS_IDLE    = 16;

  // Bits needed to hold values 0..max_val (minimum 1).
  function automatic int cnt_width(input int max_val);
    int w;
    w = 32'sd1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) <= max_val) begin
        w = i + 32'sd1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/e203_dtcm_icb2sram_chk.sv
// ---------------------------------------------------------------------------
// e203_dtcm_icb2sram_chk
// Simulation checks for the bridge's response bookkeeping. The credit limit
// rules out a FIFO overflow, and these assertions make any slip visible.
// Ports: i_clk/i_rst_n; i_push/i_pop/i_fifo_full/i_fifo_cnt come from the
// response FIFO; i_cred is the outstanding-response credit.
// ---------------------------------------------------------------------------
module e203_dtcm_icb2sram_chk (
  input logic       i_clk,
  input logic       i_rst_n,
  input logic       i_push,
  input logic       i_pop,
  input logic       i_fifo_full,
  input logic [1:0] i_fifo_cnt,
  input logic [1:0] i_cred
);

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_push && i_fifo_full && !i_pop));

  a_cred_max: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_cred <= 2'd2);

  a_fifo_within_cred: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_fifo_cnt <= i_cred);

endmodule

// File: rtl/e203_dtcm_rsp_fifo.sv
// ---------------------------------------------------------------------------
// e203_dtcm_rsp_fifo
// Two-entry {err, rdata} response FIFO. Push and pop may happen in the same
// cycle, including when it is full.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_push with
// i_push_err/i_push_data write an entry; i_pop drops the head;
// o_head_err/o_head_data show the head; o_count/o_nonempty/o_full give
// the occupancy.
// ---------------------------------------------------------------------------
module e203_dtcm_rsp_fifo #(
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic          i_push_err,
  input  logic [DW-1:0] i_push_data,
  input  logic          i_pop,
  output logic          o_head_err,
  output logic [DW-1:0] o_head_data,
  output logic [1:0]    o_count,
  output logic          o_nonempty,
  output logic          o_full
);

  logic [1:0]         r_err;
  logic [1:0][DW-1:0] r_data;
  logic               r_wptr;
  logic               r_rptr;
  logic [1:0]         r_cnt;
  logic               w_do_pop;
  logic               w_do_push;

  assign w_do_pop  = i_pop & (r_cnt != 2'd0);
  // If a pop frees a slot in this cycle, a push into a full FIFO is allowed.
  assign w_do_push = i_push & ((r_cnt != 2'd2) | w_do_pop);

  // Entry storage and the write pointer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err  <= 2'b00;
      r_data <= '0;
      r_wptr <= 1'b0;
    end else if (w_do_push) begin
      r_err[r_wptr]  <= i_push_err;
      r_data[r_wptr] <= i_push_data;
      r_wptr         <= ~r_wptr;
    end else begin
      r_wptr <= r_wptr;
    end
  end

  // Read pointer and the occupancy count
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (w_do_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_head_err  = r_err[r_rptr];
  assign o_head_data = r_data[r_rptr];
  assign o_count     = r_cnt;
  assign o_nonempty  = (r_cnt != 2'd0);
  assign o_full      = (r_cnt == 2'd2);

endmodule

// File: rtl/e203_dtcm_icb2sram.sv
// ---------------------------------------------------------------------------
// e203_dtcm_icb2sram
// Connects the DTCM ICB arbiter to the e203_dtcm_ram SRAM macro. An accepted
// command becomes a single-cycle SRAM strobe. Responses come back in command
// order. They bypass straight from the pending stage or, under backpressure,
// pass through a 2-entry FIFO. The bridge also puts the SRAM into light
// sleep after LS_IDLE idle cycles.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   icb_cmd_*            command channel (valid/ready, byte addr, read, wdata, wmask)
//   icb_rsp_*            response channel (valid/ready, err, rdata)
//   ram_cs/we/addr/wem/din, ram_dout   SRAM port (dout valid the cycle after cs)
//   ram_sd, ram_ds, ram_ls             SRAM power controls
//   idle                 nothing outstanding and no command presented
// ---------------------------------------------------------------------------
module e203_dtcm_icb2sram
  import e203_dtcm_icb2sram_pkg::*;
#(
  parameter int RAM_AW  = E203_DTCM_RAM_AW,
  parameter int RAM_DW  = E203_DTCM_RAM_DW,
  parameter int RAM_MW  = E203_DTCM_RAM_MW,
  parameter int CMD_AW  = E203_DTCM_ADDR_WIDTH,
  parameter int LS_IDLE = E203_DTCM_LS_IDLE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icb_cmd_valid,
  output logic              icb_cmd_ready,
  input  logic [CMD_AW-1:0] icb_cmd_addr,
  input  logic              icb_cmd_read,
  input  logic [RAM_DW-1:0] icb_cmd_wdata,
  input  logic [RAM_MW-1:0] icb_cmd_wmask,
  output logic              icb_rsp_valid,
  input  logic              icb_rsp_ready,
  output logic              icb_rsp_err,
  output logic [RAM_DW-1:0] icb_rsp_rdata,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [RAM_MW-1:0] ram_wem,
  output logic [RAM_DW-1:0] ram_din,
  input  logic [RAM_DW-1:0] ram_dout,
  output logic              ram_sd,
  output logic              ram_ds,
  output logic              ram_ls,
  output logic              idle
);

  localparam int              CW     = cnt_width(LS_IDLE);
  localparam logic [CW-1:0]   LS_MAX = CW'(LS_IDLE);
  localparam bit              LS_EN  = (LS_IDLE > 0);
  localparam logic [CW-1:0]   LS_ARM = (LS_IDLE > 0) ? CW'(LS_IDLE - 1) : '0;

  logic [1:0]        r_cred;
  logic              r_pend_vld;
  logic              r_pend_read;
  logic              r_pend_err;
  logic              r_ram_ls;
  logic [CW-1:0]     r_idle_cnt;

  logic              w_cmd_ready;
  logic              w_cmd_hs;
  logic              w_rsp_hs;
  logic              w_range_err;
  logic              w_idle;
  logic [RAM_DW-1:0] w_pend_rdata;
  logic              w_push;
  logic              w_pop;
  logic              w_fifo_ne;
  logic              w_fifo_full;
  logic [1:0]        w_fifo_cnt;
  logic              w_head_err;
  logic [RAM_DW-1:0] w_head_data;
  logic              w_rsp_err;
  logic [RAM_DW-1:0] w_rsp_rdata;
  logic              w_unused_addr;

  // Byte-lane bits of the address carry no meaning for word accesses.
  assign w_unused_addr = ^icb_cmd_addr[1:0];

  generate
    if (CMD_AW > RAM_AW + 2) begin : g_range
      assign w_range_err = |icb_cmd_addr[CMD_AW-1:RAM_AW+2];
    end else begin : g_no_range
      assign w_range_err = 1'b0;
    end
  endgenerate

  // icb_cmd_ready is built only from registered state, so it never depends on icb_rsp_ready.
  assign w_cmd_ready = (r_cred < 2'd2) & ~r_ram_ls;
  assign w_cmd_hs    = icb_cmd_valid & w_cmd_ready;
  assign w_rsp_hs    = icb_rsp_valid & icb_rsp_ready;
  assign w_idle      = (r_cred == 2'd0) & ~icb_cmd_valid;

  assign icb_cmd_ready = w_cmd_ready;
  assign idle          = w_idle;

  // SRAM strobe
  assign ram_cs   = w_cmd_hs & ~w_range_err;
  assign ram_we   = ~icb_cmd_read;
  assign ram_addr = icb_cmd_addr[RAM_AW+1:2];
  assign ram_wem  = icb_cmd_wmask & {RAM_MW{ram_we}};
  assign ram_din  = icb_cmd_wdata;
  assign ram_sd   = 1'b0;
  assign ram_ds   = 1'b0;
  assign ram_ls   = r_ram_ls;

  // Outstanding-response credit: +1 per accepted command, -1 per delivered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cred <= 2'd0;
    end else if (w_cmd_hs && !w_rsp_hs) begin
      r_cred <= r_cred + 2'd1;
    end else if (!w_cmd_hs && w_rsp_hs) begin
      r_cred <= r_cred - 2'd1;
    end else begin
      r_cred <= r_cred;
    end
  end

  // Pending stage: the command accepted in the previous cycle, while the SRAM produces its data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_vld  <= 1'b0;
      r_pend_read <= 1'b0;
      r_pend_err  <= 1'b0;
    end else begin
      r_pend_vld <= w_cmd_hs;
      if (w_cmd_hs) begin
        r_pend_read <= icb_cmd_read;
        r_pend_err  <= w_range_err;
      end
    end
  end

  // ram_dout is valid only in the cycle after cs, so the pending entry is captured then or never.
  assign w_pend_rdata = (r_pend_read & ~r_pend_err) ? ram_dout : {RAM_DW{1'b0}};
  assign w_push       = r_pend_vld & (w_fifo_ne | ~icb_rsp_ready);
  assign w_pop        = w_fifo_ne & icb_rsp_ready;

  e203_dtcm_rsp_fifo #(
    .DW (RAM_DW)
  ) u_rsp_fifo (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_push      (w_push),
    .i_push_err  (r_pend_err),
    .i_push_data (w_pend_rdata),
    .i_pop       (w_pop),
    .o_head_err  (w_head_err),
    .o_head_data (w_head_data),
    .o_count     (w_fifo_cnt),
    .o_nonempty  (w_fifo_ne),
    .o_full      (w_fifo_full)
  );

  // Response select: the FIFO head is older than the pending entry, so it goes first
  always_comb begin
    w_rsp_err   = 1'b0;
    w_rsp_rdata = {RAM_DW{1'b0}};
    if (w_fifo_ne) begin
      w_rsp_err   = w_head_err;
      w_rsp_rdata = w_head_data;
    end else begin
      w_rsp_err   = r_pend_err;
      w_rsp_rdata = w_pend_rdata;
    end
  end

  assign icb_rsp_valid = w_fifo_ne | r_pend_vld;
  assign icb_rsp_err   = w_rsp_err;
  assign icb_rsp_rdata = w_rsp_rdata;

  // Light-sleep control: count idle cycles, sleep at LS_IDLE, wake on a presented command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_ls   <= 1'b0;
      r_idle_cnt <= '0;
    end else if (r_ram_ls && icb_cmd_valid) begin
      r_ram_ls   <= 1'b0;
      r_idle_cnt <= '0;
    end else if (w_idle) begin
      if (r_idle_cnt != LS_MAX) begin
        r_idle_cnt <= r_idle_cnt + CW'(1'b1);
      end
      if (LS_EN && (r_idle_cnt == LS_ARM)) begin
        r_ram_ls <= 1'b1;
      end
    end else begin
      r_idle_cnt <= '0;
    end
  end

  e203_dtcm_icb2sram_chk u_chk (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_fifo_full (w_fifo_full),
    .i_fifo_cnt  (w_fifo_cnt),
    .i_cred      (r_cred)
  );

endmodule

// File: doc/e203_dtcm_icb2sram.md
Name: e203_dtcm_icb2sram

Overview:
- ICB-side initiator that drives the DTCM SRAM macro port: cs/we/addr/wem/din out, dout back one cycle later.
- Sits between the DTCM ICB arbiter and e203_dtcm_ram.
- Converts valid/ready commands into single-cycle SRAM strobes and returns in-order responses through a 2-entry response buffer, so throughput stays at one per cycle under response backpressure.
- Owns SRAM light-sleep (ls) entry and exit on idle.

Parameters:
- RAM_AW, 12, SRAM word-address width (DP = 2**RAM_AW).
- RAM_DW, 32, SRAM data width.
- RAM_MW, 4, SRAM write-enable mask width (RAM_DW/8).
- CMD_AW, 16, ICB byte-address width; must be ≥ RAM_AW+2.
- LS_IDLE, 16, idle cycles before ram_ls asserts; 0 disables light sleep.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- icb_cmd_valid  in  1  command valid.
- icb_cmd_ready  out  1  command ready.
- icb_cmd_addr  in  CMD_AW  byte address; bits [1:0] ignored.
- icb_cmd_read  in  1  1=read, 0=write.
- icb_cmd_wdata  in  RAM_DW  write data.
- icb_cmd_wmask  in  RAM_MW  byte mask.
- icb_rsp_valid  out  1  response valid.
- icb_rsp_ready  in  1  response ready.
- icb_rsp_err  out  1  out-of-range error.
- icb_rsp_rdata  out  RAM_DW  read data; 0 for writes and errors.
- ram_cs  out  1  SRAM chip select.
- ram_we  out  1  SRAM write enable.
- ram_addr  out  RAM_AW  SRAM word address.
- ram_wem  out  RAM_MW  SRAM byte write mask.
- ram_din  out  RAM_DW  SRAM write data.
- ram_dout  in  RAM_DW  SRAM read data; valid the cycle after cs.
- ram_sd, ram_ds  out  1  tied 0.
- ram_ls  out  1  SRAM light sleep.
- idle  out  1  no transaction outstanding and no command pending.

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous, active-low reset.
- Reset values: cred=0, pend_vld=0, FIFO empty, ram_ls=0, idle counter=0.
  - Consequently icb_rsp_valid=0 and icb_cmd_ready=1.
  - ram_cs=0 unless a command is presented.
- Credit counter cred (0..2): number of accepted commands whose response has not yet been handshaken.
  - +1 on command handshake; -1 on response handshake; both in one cycle leaves it unchanged.
- icb_cmd_ready = (cred < 2) & ~ram_ls. It has no combinational path from icb_rsp_ready.
- Range check: range_err = |icb_cmd_addr[CMD_AW-1:RAM_AW+2].
- SRAM strobe (combinational):
  - ram_cs = cmd handshake & ~range_err.
  - ram_we = ~icb_cmd_read.
  - ram_addr = icb_cmd_addr[RAM_AW+1:2].
  - ram_wem = icb_cmd_wmask & {RAM_MW{ram_we}}.
  - ram_din = icb_cmd_wdata.
- Pending stage: on a command handshake, the register {pend_vld, pend_read, pend_err} loads for the next cycle. Exactly one pending slot exists.
- Response source:
  - If the FIFO is non-empty, the FIFO head.
  - Otherwise the pending stage (bypass), with rdata = (pend_read & ~pend_err) ? ram_dout : 0.
- icb_rsp_valid = fifo_nonempty | pend_vld.
- Latency with icb_rsp_ready=1 and FIFO empty: response valid in cycle T+1 after an accept in T.
- Capture: when pend_vld and the pending entry is not consumed this cycle (FIFO non-empty, or icb_rsp_ready=0), push {err, rdata} into the 2-entry FIFO. ram_dout is sampled only in that cycle.
- Order: responses are strictly in command order. Push and pop in the same cycle are legal.
- Capacity: FIFO overflow is impossible because cred ≤ 2; the implementation asserts this in simulation.
- Errored commands: ram_cs stays 0; the response has err=1 and rdata=0.
- Light sleep:
  - The idle counter increments while cred==0 and ~icb_cmd_valid; otherwise it clears.
  - When the count reaches LS_IDLE (LS_IDLE≠0), ram_ls←1.
  - While ram_ls=1, icb_cmd_valid causes ram_ls←0 next cycle and clears the counter; the command is accepted one cycle later (1-cycle wake penalty).
- Reset mid-operation: pending and FIFO entries are discarded and no response is issued. The ICB master resets in the same domain.
- idle = (cred==0) & ~icb_cmd_valid.

Decomposition:
- Shared package entry: add the defines E203_DTCM_RAM_AW/DW/MW and the DTCM ICB address width to e203_defines.v.
- Instantiate these from the defines at the e203_dtcm_ctrl level.
- One sub-module, e203_dtcm_rsp_fifo: 2-entry {err, rdata} FIFO with push/pop, count, and same-cycle push+pop.

Test Plan:
- Read round-trip: write addr 0x0010 data 0xA5A5_1234 mask 0xF, then read 0x0010 with rsp_ready=1.
  - Expect ram_cs pulse with ram_addr=0x004 and ram_wem=0xF.
  - Read rsp_valid at T+1 with rdata=0xA5A5_1234 and err=0.
- Back-to-back throughput: 8 reads at 0x0000..0x001C with rsp_ready=1.
  - Expect one accept per cycle, cmd_ready held 1, and in-order rdata.
- Backpressure: rsp_ready=0, issue 3 reads.
  - Expect 2 accepted, then cmd_ready=0 and FIFO full.
  - Raise rsp_ready: 2 responses in order, then the third is accepted.
- Range error: read 0x4000 (RAM_AW=12).
  - Expect ram_cs=0, rsp err=1, rdata=0.
  - Partial write mask 0x3 gives ram_wem=0x3.
- Light sleep: idle 16 cycles → ram_ls=1. Then cmd_valid:
  - next cycle ram_ls=0;
  - accept one cycle later;
  - response correct.
- Async reset with 2 responses buffered: assert rst_n low mid-cycle.
  - Expect immediate rsp_valid=0, ram_ls=0, cmd_ready=1.
  - No stale response after release.
